// File: rtl/demux_1_4_pkg.sv
// Shared constants, lane-select type and decode helper for demux_1_4.
// Optional per-lane hit counters are enabled with DEMUX_1_4_HIT_CNT_EN.
package demux_1_4_pkg;

    localparam int N_OUT = 4;
    localparam int SEL_W = 2;

    typedef logic [SEL_W-1:0] sel_t;

    // One bit per lane; an X/Z select propagates as X.
    function automatic logic [N_OUT-1:0] onehot4(sel_t s);
        return N_OUT'(1) << s;
    endfunction

endpackage

// File: rtl/demux_1_4_if.sv
// Data/select in, lane outputs back for demux_1_4.
// Width follows the WIDTH parameter of the attached demux.
interface demux_1_4_if
    import demux_1_4_pkg::*;
#(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0]       I;
    sel_t                   S;
    logic [N_OUT*WIDTH-1:0] Y;
    logic [N_OUT*WIDTH-1:0] y_q;

    modport master (
        output I,
        output S,
        input  Y,
        input  y_q
    );

    modport slave (
        input  I,
        input  S,
        output Y,
        output y_q
    );
endinterface

// File: rtl/demux_1_4_satcnt.sv
// Saturating up-counter with async active-low clear.
// Used per lane by demux_1_4 under DEMUX_1_4_HIT_CNT_EN.
module demux_1_4_satcnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);
    logic [CNT_W-1:0] r_cnt;

    // Count one per enabled edge, holding at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/demux_1_4.sv
// 1-to-4 demux: combinational lanes Y plus registered copy y_q.
// Define DEMUX_1_4_HIT_CNT_EN to add saturating per-lane hit counters.
module demux_1_4
    import demux_1_4_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef DEMUX_1_4_HIT_CNT_EN
    output logic [N_OUT*CNT_W-1:0] hit_cnt,
`endif
    demux_1_4_if.slave       bus
);
    logic [N_OUT-1:0]       w_mask;
    logic [N_OUT*WIDTH-1:0] w_y;
    logic [N_OUT*WIDTH-1:0] r_y_q;

    assign w_mask = onehot4(bus.S);

    for (genvar k = 0; k < N_OUT; k++) begin : g_lane
        assign w_y[k*WIDTH +: WIDTH] = bus.I & {WIDTH{w_mask[k]}};
    end

    assign bus.Y = w_y;

    // Clocked view of the lanes; async clear, no enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y_q <= '0;
        end else begin
            r_y_q <= w_y;
        end
    end

    assign bus.y_q = r_y_q;

`ifdef DEMUX_1_4_HIT_CNT_EN
    for (genvar k = 0; k < N_OUT; k++) begin : g_cnt
        demux_1_4_satcnt #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .i_inc (|w_y[k*WIDTH +: WIDTH]),
            .o_cnt (hit_cnt[k*CNT_W +: CNT_W])
        );
    end
`endif
endmodule

// File: tb/tb_demux_1_4.sv
// Self-checking bench for demux_1_4 (WIDTH=1 and WIDTH=8 instances).
// Counter checks run when DEMUX_1_4_HIT_CNT_EN is defined.
module tb_demux_1_4;
    localparam int CW = 4;

    logic clk;
    logic rst_n;

    int errs;
    int checks;

    demux_1_4_if #(.WIDTH(1)) if1 ();
    demux_1_4_if #(.WIDTH(8)) if8 ();

`ifdef DEMUX_1_4_HIT_CNT_EN
    logic [4*CW-1:0] hc1;
    logic [4*CW-1:0] hc8;
`endif

    demux_1_4 #(.WIDTH(1), .CNT_W(CW)) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef DEMUX_1_4_HIT_CNT_EN
        .hit_cnt (hc1),
`endif
        .bus     (if1)
    );

    demux_1_4 #(.WIDTH(8), .CNT_W(CW)) dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef DEMUX_1_4_HIT_CNT_EN
        .hit_cnt (hc8),
`endif
        .bus     (if8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: lane s carries i, others zero.
    function automatic logic [31:0] ref_y(int w, logic [7:0] i,
                                          logic [1:0] s);
        logic [31:0] v;
        v = 32'(i) & ((32'd1 << w) - 32'd1);
        return v << (w * int'(s));
    endfunction

    function automatic int nz_lanes(int w, logic [31:0] y);
        int n;
        logic [31:0] m;
        n = 0;
        m = (32'd1 << w) - 32'd1;
        for (int k = 0; k < 4; k++) begin
            if (((y >> (k * w)) & m) != 0) n++;
        end
        return n;
    endfunction

    typedef struct {
        logic       i;
        logic [1:0] s;
        logic [3:0] y;
    } vec_t;

    vec_t tv[6];

    logic [31:0] e1;
    logic [31:0] e8;
    logic [31:0] p1;
    logic [31:0] p8;
    logic [7:0]  ri;
    logic [1:0]  rs;
    logic [1:0]  rs8;
`ifdef DEMUX_1_4_HIT_CNT_EN
    int mcnt[4];
`endif

    initial begin
        errs   = 0;
        checks = 0;
        tv[0] = '{1'b1, 2'd0, 4'b0001};
        tv[1] = '{1'b1, 2'd1, 4'b0010};
        tv[2] = '{1'b1, 2'd2, 4'b0100};
        tv[3] = '{1'b1, 2'd3, 4'b1000};
        tv[4] = '{1'b0, 2'd1, 4'b0000};
        tv[5] = '{1'b0, 2'd2, 4'b0000};

        rst_n  = 1'b0;
        if1.I  = '0;
        if1.S  = '0;
        if8.I  = '0;
        if8.S  = '0;
        #1;
        chk("reset_yq1", 32'(if1.y_q), 32'h0);
        chk("reset_yq8", if8.y_q, 32'h0);
`ifdef DEMUX_1_4_HIT_CNT_EN
        chk("reset_cnt", 32'(hc1), 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if1.I = tv[n].i;
            if1.S = tv[n].s;
            #1;
            chk($sformatf("tab_y[%0d]", n), 32'(if1.Y), 32'(tv[n].y));
            repeat (10) @(negedge clk);
            chk($sformatf("tab_yq[%0d]", n), 32'(if1.y_q), 32'(tv[n].y));
        end

        @(negedge clk);
        if1.I = 1'b1;
        if1.S = 2'd3;
        @(negedge clk);
        if1.I = 1'b0;
        #1;
        chk("i0_y_now", 32'(if1.Y), 32'h0);
        chk("i0_yq_old", 32'(if1.y_q), 32'h8);
        @(posedge clk);
        #1;
        chk("i0_yq_edge", 32'(if1.y_q), 32'h0);

        @(negedge clk);
        if1.I = 1'b1;
        if1.S = 2'd2;
        #1;
        chk("lat_y", 32'(if1.Y), 32'h4);
        chk("lat_yq_pre", 32'(if1.y_q), 32'h0);
        @(posedge clk);
        #1;
        chk("lat_yq_post", 32'(if1.y_q), 32'h4);

        @(negedge clk);
        if1.S = 2'd3;
        @(posedge clk);
        #1;
        chk("rst_yq_pre", 32'(if1.y_q), 32'h8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_yq_async", 32'(if1.y_q), 32'h0);
        chk("rst_y_kept", 32'(if1.Y), 32'h8);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_yq_wait", 32'(if1.y_q), 32'h0);
        @(posedge clk);
        #1;
        chk("rst_yq_resume", 32'(if1.y_q), 32'h8);

        @(negedge clk);
        if8.I = 8'hA5;
        if8.S = 2'd2;
        #1;
        chk("w8_y", if8.Y, 32'h00A50000);
        @(posedge clk);
        #1;
        chk("w8_yq", if8.y_q, 32'h00A50000);

`ifdef DEMUX_1_4_HIT_CNT_EN
        @(negedge clk);
        if1.I = 1'b1;
        if1.S = 2'd1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (14) @(posedge clk);
        #1;
        chk("cnt_14", 32'(hc1), 32'h00E0);
        repeat (6) @(posedge clk);
        #1;
        chk("cnt_sat", 32'(hc1), 32'h00F0);
`endif

        @(negedge clk);
        if1.I = 1'b0;
        if8.I = 8'h00;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        p1 = '0;
        p8 = '0;
`ifdef DEMUX_1_4_HIT_CNT_EN
        for (int k = 0; k < 4; k++) mcnt[k] = 0;
`endif
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            chk("rnd_yq1", 32'(if1.y_q), p1);
            chk("rnd_yq8", if8.y_q, p8);
            chk("rnd_1hot_q", 32'(nz_lanes(8, if8.y_q) <= 1), 32'h1);
`ifdef DEMUX_1_4_HIT_CNT_EN
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("rnd_cnt%0d", k),
                    32'(hc1[k*CW +: CW]), 32'(mcnt[k]));
            end
`endif
            ri  = 8'($urandom);
            if ($urandom_range(0, 3) == 0) ri = 8'h00;
            rs  = 2'($urandom);
            rs8 = 2'($urandom);
            if1.I = ri[0];
            if1.S = rs;
            if8.I = ri;
            if8.S = rs8;
            #1;
            e1 = ref_y(1, ri, rs);
            e8 = ref_y(8, ri, rs8);
            chk("rnd_y1", 32'(if1.Y), e1);
            chk("rnd_y8", if8.Y, e8);
            p1 = e1;
            p8 = e8;
`ifdef DEMUX_1_4_HIT_CNT_EN
            if (ri[0] && mcnt[rs] < (1 << CW) - 1) mcnt[rs]++;
`endif
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
